lsu: RTL and testbench

Load/store unit for Polaris. Accepts one memory request at a time from the execute stage and breaks it into byte or halfword cycles on the 16-bit external data bus. It returns sign- or zero-extended load data and drives the pause that holds the instruction fetcher (`pause_i` of `fetch`) while an access is in flight. It also flags misaligned accesses for the trap logic.

---
 rtl/lsu_if.sv | 31 +++
 rtl/lsu.sv | 137 +++++++++++++
 tb/tb_lsu.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Request and bus signals of the Polaris load/store unit.
// slave is the LSU side; master is the execute stage / bus side.
interface lsu_if;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        signed_i;
  logic [63:0] adr_i;
  logic [63:0] sdat_i;
  logic        ack_i;
  logic [15:0] dat_i;
  logic [63:0] adr_o;
  logic [15:0] dat_o;
  logic [1:0]  size_o;
  logic        we_o;
  logic        vda_o;
  logic        busy_o;
  logic        done_o;
  logic        misaligned_o;
  logic [63:0] rdat_o;

  modport slave (
    input  req_i, we_i, size_i, signed_i, adr_i, sdat_i, ack_i, dat_i,
    output adr_o, dat_o, size_o, we_o, vda_o, busy_o, done_o, misaligned_o, rdat_o
  );

  modport master (
    output req_i, we_i, size_i, signed_i, adr_i, sdat_i, ack_i, dat_i,
    input  adr_o, dat_o, size_o, we_o, vda_o, busy_o, done_o, misaligned_o, rdat_o
  );
endinterface

// File: rtl/lsu.sv
// Polaris load/store unit: splits one byte/half/word/dword request into
// byte or halfword cycles on a 16-bit bus, extends load data, pauses fetch.
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned requests trap
// through a FAULT state; when undefined the address is aligned down instead.
module lsu (
  input  logic   clk_i,
  input  logic   reset_i,
  lsu_if.slave   bus
);

`ifdef LSU_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE, BUS, DONE, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [63:0] adr_q, sdat_q, acc_q, rdat_q;
  logic [1:0]  size_q, beat_q;
  logic        we_q, sgn_q;
  logic        accept, in_bus, last_beat, fault_go;
  logic [63:0] adr_lat, ext;

  assign accept = (state_q == IDLE) && bus.req_i;
  assign in_bus = (state_q == BUS);

`ifdef LSU_MISALIGN_TRAP_EN
  // Alignment check on the incoming request; the address is taken as-is
  always_comb begin
    fault_go = 1'b0;
    case (bus.size_i)
      2'd1:    fault_go = bus.adr_i[0];
      2'd2:    fault_go = |bus.adr_i[1:0];
      2'd3:    fault_go = |bus.adr_i[2:0];
      default: fault_go = 1'b0;
    endcase
    adr_lat = bus.adr_i;
  end
`else
  // No trap: force the address down to the natural boundary of the size
  always_comb begin
    fault_go = 1'b0;
    adr_lat  = bus.adr_i;
    case (bus.size_i)
      2'd1:    adr_lat[0]   = 1'b0;
      2'd2:    adr_lat[1:0] = 2'b00;
      2'd3:    adr_lat[2:0] = 3'b000;
      default: adr_lat      = bus.adr_i;
    endcase
  end
`endif

  // Final beat of the latched access: byte/half 1, word 2, dword 4
  always_comb begin
    case (size_q)
      2'd2:    last_beat = (beat_q == 2'd1);
      2'd3:    last_beat = (beat_q == 2'd3);
      default: last_beat = (beat_q == 2'd0);
    endcase
  end

  // Load result extension from the accumulator
  always_comb begin
    case (size_q)
      2'd0:    ext = {{56{sgn_q & acc_q[7]}},  acc_q[7:0]};
      2'd1:    ext = {{48{sgn_q & acc_q[15]}}, acc_q[15:0]};
      2'd2:    ext = {{32{sgn_q & acc_q[31]}}, acc_q[31:0]};
      default: ext = acc_q;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_i) state_d = fault_go ? state_t'(2'd3) : BUS;
      BUS:     if (bus.ack_i && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, beat counter, load accumulator and result register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      adr_q  <= '0;
      sdat_q <= '0;
      size_q <= '0;
      we_q   <= 1'b0;
      sgn_q  <= 1'b0;
      beat_q <= '0;
      acc_q  <= '0;
      rdat_q <= '0;
    end else begin
      if (accept) begin
        adr_q  <= adr_lat;
        sdat_q <= bus.sdat_i;
        size_q <= bus.size_i;
        we_q   <= bus.we_i;
        sgn_q  <= bus.signed_i;
        beat_q <= '0;
      end
      if (in_bus && bus.ack_i) begin
        if (!we_q)
          acc_q[{beat_q, 4'b0000} +: 16] <= (size_q == 2'd0) ? {8'h00, bus.dat_i[7:0]} : bus.dat_i;
        if (!last_beat) beat_q <= beat_q + 2'd1;
      end
      if (state_q == DONE && !we_q) rdat_q <= ext;
    end
  end

  // Bus and status outputs, all derived from registered state
  always_comb begin
    bus.vda_o  = in_bus;
    bus.size_o = in_bus ? ((size_q == 2'd0) ? 2'b01 : 2'b10) : 2'b00;
    bus.adr_o  = in_bus ? adr_q + {61'd0, beat_q, 1'b0} : 64'd0;
    bus.dat_o  = 16'd0;
    if (in_bus)
      bus.dat_o = (size_q == 2'd0) ? {8'h00, sdat_q[7:0]} : sdat_q[{beat_q, 4'b0000} +: 16];
    bus.we_o   = in_bus & we_q;
    bus.busy_o = accept | in_bus;
    bus.done_o = (state_q == DONE);
`ifdef LSU_MISALIGN_TRAP_EN
    bus.misaligned_o = (state_q == state_t'(2'd3));
`else
    bus.misaligned_o = 1'b0;
`endif
    bus.rdat_o = rdat_q;
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized accesses,
// checked cycle by cycle against a transaction-level model of the unit.
module tb_lsu;
  logic clk_i = 1'b0;
  logic reset_i;
  lsu_if bus ();

  lsu dut (.clk_i(clk_i), .reset_i(reset_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle
  logic        e_vda, e_we, e_busy, e_done, e_mis;
  logic [1:0]  e_size;
  logic [63:0] e_adr, m_rdat;
  logic [15:0] e_dat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("vda_o",        64'(bus.vda_o),        64'(e_vda));
      chk("size_o",       64'(bus.size_o),       64'(e_size));
      chk("adr_o",        bus.adr_o,             e_adr);
      chk("dat_o",        64'(bus.dat_o),        64'(e_dat));
      chk("we_o",         64'(bus.we_o),         64'(e_we));
      chk("busy_o",       64'(bus.busy_o),       64'(e_busy));
      chk("done_o",       64'(bus.done_o),       64'(e_done));
      chk("misaligned_o", 64'(bus.misaligned_o), 64'(e_mis));
      chk("rdat_o",       bus.rdat_o,            m_rdat);
    end
  end

  task automatic set_idle();
    e_vda = 0; e_size = 0; e_adr = 0; e_dat = 0;
    e_we = 0; e_busy = 0; e_done = 0; e_mis = 0;
  endtask

  task automatic rand_inputs();
    bus.we_i     = 1'($urandom);
    bus.size_i   = 2'($urandom);
    bus.signed_i = 1'($urandom);
    bus.adr_i    = {$urandom, $urandom};
    bus.sdat_i   = {$urandom, $urandom};
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Value of a load as the unit must return it
  function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] sz, input logic sg);
    int bits;
    logic [63:0] m, r;
    if (sz == 2'd3) return v;
    bits = 8 << sz;
    m = (64'd1 << bits) - 64'd1;
    r = v & m;
    if (sg && r[bits-1]) r = r | ~m;
    return r;
  endfunction

  // One complete access: rdd holds the halfwords the bus returns per beat,
  // waits<0 means random wait states, abort_beat>=0 resets inside that beat.
  task automatic access(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [63:0] adr, input logic [63:0] sdat,
                        input logic [63:0] rdd, input int waits,
                        input bit pulse, input int abort_beat);
    logic [63:0] base, got;
    logic [15:0] hw;
    int n, w;
    bit mis;
    bus.req_i = 1; bus.we_i = we; bus.size_i = sz; bus.signed_i = sg;
    bus.adr_i = adr; bus.sdat_i = sdat; bus.ack_i = 0; bus.dat_i = 16'($urandom);
    set_idle(); e_busy = 1;
    tick();
    n = (sz == 2'd3) ? 4 : (sz == 2'd2) ? 2 : 1;
    mis = (sz == 2'd1 && adr[0]) || (sz == 2'd2 && adr[1:0] != 0) || (sz == 2'd3 && adr[2:0] != 0);
    bus.req_i = 0; rand_inputs();
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      set_idle(); e_mis = 1;
      tick();
      set_idle();
      return;
    end
    base = adr;
`else
    base = adr & ~((64'd1 << sz) - 64'd1);
`endif
    got = 0;
    for (int b = 0; b < n; b++) begin
      w = (waits < 0) ? int'($urandom_range(2, 0)) : waits;
      hw = rdd[16*b +: 16];
      e_vda = 1; e_size = (sz == 2'd0) ? 2'd1 : 2'd2;
      e_adr = base + 64'(2 * b);
      e_dat = (sz == 2'd0) ? {8'h00, sdat[7:0]} : sdat[16*b +: 16];
      e_we = we; e_busy = 1; e_done = 0; e_mis = 0;
      if (b == abort_beat) begin
        bus.ack_i = 0; bus.dat_i = hw;
        tick();
        reset_i = 1; set_idle(); m_rdat = 0;
        tick();
        reset_i = 0; set_idle();
        return;
      end
      for (int k = 0; k <= w; k++) begin
        rand_inputs();
        bus.req_i = pulse && b == 0 && k == 0;
        bus.ack_i = (k == w);
        bus.dat_i = hw;
        if (!we && k == w) got[16*b +: 16] = hw;
        tick();
      end
    end
    bus.req_i = 0; bus.ack_i = 0;
    set_idle(); e_done = 1;
    tick();
    if (!we) m_rdat = extend(got, sz, sg);
    set_idle();
  endtask

  task automatic idle_cycle();
    bus.req_i = 0; bus.ack_i = 0; rand_inputs();
    set_idle();
    tick();
  endtask

  initial begin
    logic [1:0]  sz;
    logic [63:0] a;
    reset_i = 1;
    bus.req_i = 0; bus.we_i = 0; bus.size_i = 0; bus.signed_i = 0;
    bus.adr_i = 0; bus.sdat_i = 0; bus.ack_i = 0; bus.dat_i = 0;
    set_idle(); m_rdat = 0;
    chk_en = 1;
    tick(); tick();
    chk("reset_rdat", bus.rdat_o, 64'd0);
    reset_i = 0;
    idle_cycle();

    // Signed byte load
    access(0, 2'd0, 1, 64'h1001, 64'h0, 64'h0080, 0, 0, -1);
    chk("byte_lit", bus.rdat_o, 64'hFFFF_FFFF_FFFF_FF80);
    // Dword store, one wait per beat, result untouched
    access(1, 2'd3, 0, 64'h2000, 64'h1122_3344_5566_7788, 64'h0, 1, 0, -1);
    chk("store_keep", bus.rdat_o, 64'hFFFF_FFFF_FFFF_FF80);
    // Unsigned word load
    access(0, 2'd2, 0, 64'h3004, 64'h0, 64'h0000_0000_8000_BEEF, 0, 0, -1);
    chk("word_lit", bus.rdat_o, 64'h0000_0000_8000_BEEF);
    // Misaligned word load
    access(0, 2'd2, 0, 64'h3002, 64'h0, 64'h0000_0000_1234_5678, 0, 0, -1);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_lit", bus.rdat_o, 64'h0000_0000_8000_BEEF);
`else
    chk("mis_lit", bus.rdat_o, 64'h0000_0000_1234_5678);
`endif
    // Reset during beat 1 of a dword load, then a normal byte load
    access(0, 2'd3, 0, 64'h4000, 64'h0, 64'h1111_2222_3333_4444, 0, 0, 1);
    chk("abort_rdat", bus.rdat_o, 64'd0);
    access(0, 2'd0, 0, 64'h5003, 64'h0, 64'hAA55, 0, 0, -1);
    chk("after_rst", bus.rdat_o, 64'h55);
    // Request pulsed while busy is ignored
    access(1, 2'd2, 0, 64'h6008, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1, 1, -1);
    access(0, 2'd1, 1, 64'h7002, 64'h0, 64'h0000_0000_0000_9ABC, 0, 1, -1);
    chk("half_lit", bus.rdat_o, 64'hFFFF_FFFF_FFFF_9ABC);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      sz = 2'($urandom);
      a = {$urandom, $urandom};
      if ($urandom_range(1, 0) == 1) a = a & ~((64'd1 << sz) - 64'd1);
      access(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom},
             {$urandom, $urandom}, -1, $urandom_range(7, 0) == 0, -1);
      if ($urandom_range(1, 0) == 1) idle_cycle();
    end
    idle_cycle();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
